// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encodings and register-file address/field map used by the master
// and the register-file responder.
package apb_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_SETUP  = 3'b010,
    S_ACCESS = 3'b100
  } apb_state_e;

  localparam logic [31:0] REG1_ADDR = 32'h0000_0000;
  localparam logic [31:0] REG2_ADDR = 32'h0000_0004;

  localparam int unsigned REG1_PRI_LSB = 0;
  localparam int unsigned REG1_PRI_W   = 4;
  localparam int unsigned REG2_LEN_LSB = 0;
  localparam int unsigned REG2_LEN_W   = 12;
  localparam int unsigned REG2_CNT_LSB = 12;
  localparam int unsigned REG2_CNT_W   = 8;

endpackage

// File: rtl/apb2master_wdog.sv
// Wait-state watchdog: counts ACCESS cycles with pready low and flags the edge that reaches the
// limit. A TIMEOUT_CYCLES of 0 disables it.
module apb2master_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] LIMIT_M1 = ENABLED ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [TO_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && ENABLED) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  // Fires on the edge whose increment would bring the count to the limit.
  assign o_expire = ENABLED && i_inc && (r_count == LIMIT_M1);

endmodule

// File: rtl/apb2master.sv
// APB2 initiator: turns a valid/ready command into SETUP/ACCESS transfers and returns a one-cycle
// response strobe; a watchdog aborts transfers the responder never completes.
module apb2master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              i_pclk,
  input  logic              i_prst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready
);

  apb_state_e        r_state, w_state_d;
  logic              r_cmd_ready, w_cmd_ready_d;
  logic              r_psel, w_psel_d;
  logic              r_penable, w_penable_d;
  logic              r_pwrite, w_pwrite_d;
  logic [ADDR_W-1:0] r_paddr, w_paddr_d;
  logic [DATA_W-1:0] r_pdata, w_pdata_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_d;
  logic              r_rsp_err, w_rsp_err_d;
  logic              w_wdog_clr, w_wdog_inc, w_wdog_expire;

  assign w_wdog_clr = (r_state == S_SETUP);
  assign w_wdog_inc = (r_state == S_ACCESS) && !i_pready;

  apb2master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_wdog (
    .i_clk   (i_pclk),
    .i_rst   (i_prst),
    .i_clr   (w_wdog_clr),
    .i_inc   (w_wdog_inc),
    .o_expire(w_wdog_expire)
  );

  always_comb begin
    w_state_d     = r_state;
    w_pwrite_d    = r_pwrite;
    w_paddr_d     = r_paddr;
    w_pdata_d     = r_pdata;
    w_rsp_valid_d = 1'b0;
    w_rsp_rdata_d = '0;
    w_rsp_err_d   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_state_d  = S_SETUP;
          w_pwrite_d = i_cmd_write;
          w_paddr_d  = i_cmd_addr;
          w_pdata_d  = i_cmd_write ? i_cmd_wdata : '0;
        end
      end
      S_SETUP: w_state_d = S_ACCESS;
      S_ACCESS: begin
        // pready is checked first so a completion on the limit edge beats the watchdog.
        if (i_pready) begin
          w_state_d     = S_IDLE;
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = r_pwrite ? '0 : i_prdata;
        end else if (w_wdog_expire) begin
          w_state_d     = S_IDLE;
          w_rsp_valid_d = 1'b1;
          w_rsp_err_d   = 1'b1;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  assign w_cmd_ready_d = (w_state_d == S_IDLE);
  assign w_psel_d      = (w_state_d != S_IDLE);
  assign w_penable_d   = (w_state_d == S_ACCESS);

  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_psel      <= w_psel_d;
      r_penable   <= w_penable_d;
      r_pwrite    <= w_pwrite_d;
      r_paddr     <= w_paddr_d;
      r_pdata     <= w_pdata_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pdata     = r_pdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule
